pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and SoC reset release
// Optional feature macro: PLLSEQ_RETRY_COUNT_EN adds the 8-bit saturating retry_count output.
// Sequence: PLLRST -> WAITLOCK -> STABLE -> RUN, with lock loss or lock timeout
// sending the PLL back through a fresh reset pulse.

module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 250000,
   parameter int STABLE_CYCLES  = 1024
) (
   input  logic       input_clk,
   input  logic       reset,
   input  logic       pll_locked,
   output logic       pll_reset,
   output logic       soc_reset,
   output logic [1:0] seq_state
`ifdef PLLSEQ_RETRY_COUNT_EN
   ,
   output logic [7:0] retry_count
`endif
);

   // One counter serves every state, so it is sized for the longest wait.
   localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_PLLRST   = 2'd0,
      ST_WAITLOCK = 2'd1,
      ST_STABLE   = 2'd2,
      ST_RUN      = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sync1_q, sync2_q;
   logic          lock_s;
   logic          pll_reset_q, pll_reset_d;
   logic          soc_reset_q, soc_reset_d;

   assign lock_s = sync2_q;

   // Two-flop synchronizer bringing the asynchronous PLL lock into input_clk.
   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pll_locked;
         sync2_q <= sync1_q;
      end
   end

   // State, shared counter and registered reset outputs.
   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_PLLRST;
         cnt_q       <= '0;
         pll_reset_q <= 1'b1;
         soc_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pll_reset_q <= pll_reset_d;
         soc_reset_q <= soc_reset_d;
      end
   end

   // Next-state logic; lock loss is tested before any counter terminal.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      case (state_q)
         ST_PLLRST: begin
            if (cnt_q == PLLRST_LAST) begin
               state_d = ST_WAITLOCK;
               cnt_d   = '0;
            end
         end
         ST_WAITLOCK: begin
            if (lock_s) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = ST_PLLRST;
               cnt_d   = '0;
            end
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_d = ST_WAITLOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            cnt_d = '0;
            if (!lock_s) begin
               state_d = ST_PLLRST;
            end
         end
         default: begin
            state_d = ST_PLLRST;
            cnt_d   = '0;
         end
      endcase
      // Outputs are decoded from the next state so they register on the transition edge.
      pll_reset_d = (state_d == ST_PLLRST);
      soc_reset_d = (state_d != ST_RUN);
   end

   assign pll_reset = pll_reset_q;
   assign soc_reset = soc_reset_q;
   assign seq_state = state_q;

`ifdef PLLSEQ_RETRY_COUNT_EN
   logic [7:0] retry_q, retry_d;
   logic       retry_inc;

   // A retry is a lock timeout in WAITLOCK or a lock loss while running.
   always_comb begin
      retry_inc = ((state_q == ST_WAITLOCK) && !lock_s && (cnt_q == TIMEOUT_LAST)) ||
                  ((state_q == ST_RUN) && !lock_s);
      retry_d   = retry_q;
      if (retry_inc && (retry_q != 8'hFF)) begin
         retry_d = retry_q + 8'd1;
      end
   end

   // Saturating retry counter, cleared only by block reset.
   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         retry_q <= 8'd0;
      end else begin
         retry_q <= retry_d;
      end
   end

   assign retry_count = retry_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       pll_reset;
   logic       soc_reset;
   logic [1:0] seq_state;
`ifdef PLLSEQ_RETRY_COUNT_EN
   logic [7:0] retry_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8)
   ) dut (
      .input_clk  (clk),
      .reset      (rst),
      .pll_locked (pll_locked),
      .pll_reset  (pll_reset),
      .soc_reset  (soc_reset),
      .seq_state  (seq_state)
`ifdef PLLSEQ_RETRY_COUNT_EN
      ,
      .retry_count(retry_count)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds reset over two edges and releases it 1 ns after an edge; the next edge is edge 1.
   task automatic apply_reset(input logic lock);
      pll_locked = lock;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      pll_locked = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pll_reset, soc_reset, seq_state} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_hold: pll=%0b soc=%0b st=%0d, want pll=1 soc=1 st=0", pll_reset, soc_reset, seq_state);
      end
`ifdef PLLSEQ_RETRY_COUNT_EN
      checks++;
      if (retry_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_retry: got %0d want 0", retry_count);
      end
`endif
   endtask

   task automatic test_normal_start();
      logic [1:0] exp_st;
      apply_reset(1'b1);
      for (int e = 1; e <= 13; e++) begin
         step();
         if (e < 4) exp_st = 2'd0;
         else if (e == 4) exp_st = 2'd1;
         else if (e < 13) exp_st = 2'd2;
         else exp_st = 2'd3;
         checks++;
         if (pll_reset !== (e < 4) || soc_reset !== (e < 13) || seq_state !== exp_st) begin
            errors++;
            $display("FAIL normal_start edge %0d: pll=%0b soc=%0b st=%0d, want pll=%0b soc=%0b st=%0d",
                     e, pll_reset, soc_reset, seq_state, (e < 4), (e < 13), exp_st);
         end
      end
   endtask

   task automatic test_timeout();
      apply_reset(1'b0);
      for (int e = 1; e <= 100; e++) begin
         step();
         checks++;
         if (pll_reset !== ((e % 24) < 4) || soc_reset !== 1'b1) begin
            errors++;
            $display("FAIL timeout edge %0d: pll=%0b soc=%0b, want pll=%0b soc=1",
                     e, pll_reset, soc_reset, ((e % 24) < 4));
         end
      end
`ifdef PLLSEQ_RETRY_COUNT_EN
      checks++;
      if (retry_count !== 8'd4) begin
         errors++;
         $display("FAIL timeout_retry: got %0d want 4", retry_count);
      end
`endif
   endtask

   task automatic test_glitchy_lock();
      logic [1:0] exp_st;
      apply_reset(1'b0);
      for (int e = 1; e <= 21; e++) begin
         step();
         if (e == 4) pll_locked = 1'b1;
         if (e == 9) pll_locked = 1'b0;
         if (e == 10) pll_locked = 1'b1;
         if (e < 4) exp_st = 2'd0;
         else if (e < 7) exp_st = 2'd1;
         else if (e < 12) exp_st = 2'd2;
         else if (e == 12) exp_st = 2'd1;
         else if (e < 21) exp_st = 2'd2;
         else exp_st = 2'd3;
         checks++;
         if (seq_state !== exp_st || soc_reset !== (exp_st != 2'd3) || pll_reset !== (exp_st == 2'd0)) begin
            errors++;
            $display("FAIL glitch edge %0d: st=%0d soc=%0b pll=%0b, want st=%0d soc=%0b pll=%0b",
                     e, seq_state, soc_reset, pll_reset, exp_st, (exp_st != 2'd3), (exp_st == 2'd0));
         end
      end
`ifdef PLLSEQ_RETRY_COUNT_EN
      checks++;
      if (retry_count !== 8'd0) begin
         errors++;
         $display("FAIL glitch_retry: got %0d want 0", retry_count);
      end
`endif
   endtask

   task automatic test_lock_loss_run();
      logic [1:0] exp_st;
      apply_reset(1'b1);
      repeat (13) step();
      checks++;
      if (seq_state !== 2'd3) begin
         errors++;
         $display("FAIL lossrun_pre: st=%0d want 3", seq_state);
      end
      pll_locked = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++;
         if (soc_reset !== (k == 3) || pll_reset !== (k == 3)) begin
            errors++;
            $display("FAIL lossrun_drop +%0d: soc=%0b pll=%0b, want both %0b", k, soc_reset, pll_reset, (k == 3));
         end
      end
      pll_locked = 1'b1;
      for (int k = 4; k <= 16; k++) begin
         step();
         if (k <= 6) exp_st = 2'd0;
         else if (k == 7) exp_st = 2'd1;
         else if (k < 16) exp_st = 2'd2;
         else exp_st = 2'd3;
         checks++;
         if (seq_state !== exp_st || soc_reset !== (k < 16) || pll_reset !== (k <= 6)) begin
            errors++;
            $display("FAIL lossrun_reseq +%0d: st=%0d soc=%0b pll=%0b, want st=%0d soc=%0b pll=%0b",
                     k, seq_state, soc_reset, pll_reset, exp_st, (k < 16), (k <= 6));
         end
      end
`ifdef PLLSEQ_RETRY_COUNT_EN
      checks++;
      if (retry_count !== 8'd1) begin
         errors++;
         $display("FAIL lossrun_retry: got %0d want 1", retry_count);
      end
`endif
   endtask

   // Runs straight after test_lock_loss_run, so the block is in RUN with one retry logged.
   task automatic test_async_reset_run();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({pll_reset, soc_reset, seq_state} !== 4'b1100) begin
         errors++;
         $display("FAIL async_reset: pll=%0b soc=%0b st=%0d, want pll=1 soc=1 st=0", pll_reset, soc_reset, seq_state);
      end
`ifdef PLLSEQ_RETRY_COUNT_EN
      checks++;
      if (retry_count !== 8'd0) begin
         errors++;
         $display("FAIL async_reset_retry: got %0d want 0", retry_count);
      end
`endif
      #1;
      rst = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         checks++;
         if (pll_reset !== (e < 4) || soc_reset !== 1'b1) begin
            errors++;
            $display("FAIL async_restart edge %0d: pll=%0b soc=%0b, want pll=%0b soc=1", e, pll_reset, soc_reset, (e < 4));
         end
      end
   endtask

`ifdef PLLSEQ_RETRY_COUNT_EN
   task automatic test_saturation();
      apply_reset(1'b0);
      for (int e = 1; e <= 7200; e++) begin
         step();
         if (e == 254 * 24) begin
            checks++;
            if (retry_count !== 8'd254) begin
               errors++;
               $display("FAIL sat_254: got %0d want 254", retry_count);
            end
         end
         if (e == 256 * 24) begin
            checks++;
            if (retry_count !== 8'd255) begin
               errors++;
               $display("FAIL sat_256: got %0d want 255", retry_count);
            end
         end
      end
      checks++;
      if (retry_count !== 8'd255) begin
         errors++;
         $display("FAIL sat_300: got %0d want 255", retry_count);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      pll_locked = 1'b0;
      test_reset();
      test_normal_start();
      test_timeout();
      test_glitchy_lock();
      test_lock_loss_run();
      test_async_reset_run();
`ifdef PLLSEQ_RETRY_COUNT_EN
      test_saturation();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
